apb_slave_mem: RTL and testbench

APB_SLAVE_MEM -- requirements
Module: apb_slave_mem

---
 rtl/apb_slave_mem.sv | 126 ++++++++++++
 tb/tb_apb_slave_mem.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/apb_slave_mem.sv
// APB slave backed by a DEPTH x APB_DW register array, with a fixed number of
// wait states per transfer and an error response for out-of-range addresses.
module apb_slave_mem #(
    parameter int APB_AW      = 32,
    parameter int APB_DW      = 8,
    parameter int DEPTH       = 16,
    parameter int WAIT_CYCLES = 2
) (
    input  logic              PCLK,
    input  logic              PRESET,
    input  logic [APB_AW-1:0] i_PADDR,
    input  logic              i_PSEL,
    input  logic              i_PENABLE,
    input  logic              i_PWRITE,
    input  logic [APB_DW-1:0] i_PWDATA,
    output logic [APB_DW-1:0] o_PRDATA,
    output logic              o_PREADY,
    output logic              o_PSLVERR
);

    localparam int ADDR_SHIFT = $clog2(APB_DW / 8);
    localparam int IDX_W      = $clog2(DEPTH);

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t            state, state_nxt;
    logic [3:0]        wait_cnt, wait_cnt_nxt;
    logic              capture;

    logic [IDX_W-1:0]  lat_idx;
    logic              lat_write;
    logic              lat_err;
    logic [APB_DW-1:0] lat_wdata;

    logic [APB_DW-1:0] mem [DEPTH];

    logic [APB_AW-1:0] addr_word;
    logic              addr_err;
    logic              setup;
    logic              enter_resp;
    logic              commit;
    logic [IDX_W-1:0]  rd_idx;
    logic              rd_err;
    logic              rd_write;

    assign addr_word = i_PADDR >> ADDR_SHIFT;
    assign addr_err  = (addr_word >= APB_AW'(DEPTH));
    assign setup     = i_PSEL && !i_PENABLE;

    always_comb begin
        state_nxt    = state;
        wait_cnt_nxt = wait_cnt;
        capture      = 1'b0;
        case (state)
            IDLE: begin
                if (setup) begin
                    capture = 1'b1;
                    if (WAIT_CYCLES == 0) begin
                        state_nxt = RESP;
                    end else begin
                        state_nxt    = WAIT;
                        wait_cnt_nxt = 4'(WAIT_CYCLES);
                    end
                end
            end
            WAIT: begin
                if (!i_PSEL) begin
                    state_nxt = IDLE;
                end else if (!i_PENABLE) begin
                    // A fresh setup phase mid-wait restarts the transfer from scratch.
                    capture      = 1'b1;
                    wait_cnt_nxt = 4'(WAIT_CYCLES);
                end else begin
                    wait_cnt_nxt = wait_cnt - 4'd1;
                    if (wait_cnt == 4'd1) begin
                        state_nxt = RESP;
                    end
                end
            end
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Read data is sampled on the edge entering RESP; with zero wait states that is
    // the setup edge itself, so the live bus fields stand in for the latched ones.
    assign rd_idx     = capture ? addr_word[IDX_W-1:0] : lat_idx;
    assign rd_err     = capture ? addr_err : lat_err;
    assign rd_write   = capture ? i_PWRITE : lat_write;
    assign enter_resp = (state_nxt == RESP) && (state != RESP);
    assign commit     = (state == RESP) && i_PSEL && lat_write && !lat_err;

    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            state     <= IDLE;
            wait_cnt  <= '0;
            lat_idx   <= '0;
            lat_write <= 1'b0;
            lat_err   <= 1'b0;
            lat_wdata <= '0;
            o_PRDATA  <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem[IDX_W'(i)] <= '0;
            end
        end else begin
            state    <= state_nxt;
            wait_cnt <= wait_cnt_nxt;
            if (capture) begin
                lat_idx   <= addr_word[IDX_W-1:0];
                lat_write <= i_PWRITE;
                lat_err   <= addr_err;
                lat_wdata <= i_PWDATA;
            end
            if (commit) begin
                mem[lat_idx] <= lat_wdata;
            end
            if (enter_resp && !rd_write) begin
                o_PRDATA <= rd_err ? '0 : mem[rd_idx];
            end
        end
    end

    assign o_PREADY  = (state == RESP);
    assign o_PSLVERR = (state == RESP) && lat_err;

endmodule

// File: tb/tb_apb_slave_mem.sv
// Bench for apb_slave_mem: two instances (2 wait states and 0 wait states) driven by
// directed and random APB transfers, checked every cycle against a transfer-level model.
module tb_apb_slave_mem;

    localparam int DEPTH     = 16;
    localparam int SHIFT     = 0;
    localparam int M_NONE    = 0;
    localparam int M_ABORT   = 1;
    localparam int M_RESTART = 2;
    localparam int M_RESET   = 3;

    logic PCLK = 1'b0;
    always #5 PCLK = ~PCLK;

    logic        preset  [2];
    logic        psel    [2];
    logic        penable [2];
    logic        pwrite  [2];
    logic [31:0] paddr   [2];
    logic [7:0]  pwdata  [2];
    logic [7:0]  prdata  [2];
    logic        pready  [2];
    logic        pslverr [2];

    logic        exp_pready  [2];
    logic        exp_pslverr [2];
    logic [7:0]  exp_prdata  [2];
    logic [7:0]  mem_m       [2][DEPTH];

    int n_checks = 0;
    int n_pass   = 0;
    bit chk_en   = 1'b0;

    apb_slave_mem #(.APB_AW(32), .APB_DW(8), .DEPTH(DEPTH), .WAIT_CYCLES(2)) dut_w2 (
        .PCLK(PCLK), .PRESET(preset[0]), .i_PADDR(paddr[0]), .i_PSEL(psel[0]),
        .i_PENABLE(penable[0]), .i_PWRITE(pwrite[0]), .i_PWDATA(pwdata[0]),
        .o_PRDATA(prdata[0]), .o_PREADY(pready[0]), .o_PSLVERR(pslverr[0])
    );

    apb_slave_mem #(.APB_AW(32), .APB_DW(8), .DEPTH(DEPTH), .WAIT_CYCLES(0)) dut_w0 (
        .PCLK(PCLK), .PRESET(preset[1]), .i_PADDR(paddr[1]), .i_PSEL(psel[1]),
        .i_PENABLE(penable[1]), .i_PWRITE(pwrite[1]), .i_PWDATA(pwdata[1]),
        .o_PRDATA(prdata[1]), .o_PREADY(pready[1]), .o_PSLVERR(pslverr[1])
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    always @(negedge PCLK) begin
        if (chk_en) begin
            for (int d = 0; d < 2; d++) begin
                check($sformatf("pready%0d", d),  pready[d],  exp_pready[d]);
                check($sformatf("pslverr%0d", d), pslverr[d], exp_pslverr[d]);
                check($sformatf("prdata%0d", d),  prdata[d],  exp_prdata[d]);
            end
        end
    end

    // Advance one cycle for bus d; a reset requested last cycle takes effect here.
    task automatic step(input int d);
        @(posedge PCLK);
        #1;
        if (preset[d]) begin
            for (int i = 0; i < DEPTH; i++) mem_m[d][i] = 8'h00;
            exp_prdata[d] = 8'h00;
            preset[d]     = 1'b0;
        end
        exp_pready[d]  = 1'b0;
        exp_pslverr[d] = 1'b0;
    endtask

    task automatic idle(input int d);
        step(d);
        psel[d]    = 1'b0;
        penable[d] = 1'b0;
    endtask

    // One transfer: mode/sk select an abort, restart or reset in access cycle sk.
    task automatic xfer(input int d, input logic [31:0] addr, input logic wr,
                        input logic [7:0] wd, input int mode, input int sk);
        int          w    = (d == 0) ? 2 : 0;
        logic [31:0] widx = addr >> SHIFT;
        logic        err  = (widx >= 32'(DEPTH));
        int          idx  = err ? 0 : int'(widx);
        step(d);
        psel[d]    = 1'b1;
        penable[d] = 1'b0;
        paddr[d]   = addr;
        pwrite[d]  = wr;
        pwdata[d]  = wd;
        for (int k = 1; k <= w + 1; k++) begin
            if (mode == M_RESTART && k == sk) return;
            step(d);
            if (k == w + 1) begin
                exp_pready[d]  = 1'b1;
                exp_pslverr[d] = err;
                if (!wr) exp_prdata[d] = err ? 8'h00 : mem_m[d][idx];
            end
            penable[d] = 1'b1;
            if (mode == M_RESET && k == sk) begin
                preset[d] = 1'b1;
                return;
            end
            if (mode == M_ABORT && k == sk) begin
                psel[d]    = 1'b0;
                penable[d] = 1'b0;
                return;
            end
            if (k == w + 1 && wr && !err) mem_m[d][idx] = wd;
        end
    endtask

    task automatic lit(input string name, input int d, input bit chk_rd,
                       input logic [7:0] rd, input logic err);
        @(negedge PCLK);
        check({name, "_ready"}, pready[d], 32'd1);
        check({name, "_slverr"}, pslverr[d], err);
        if (chk_rd) check({name, "_rdata"}, prdata[d], rd);
    endtask

    task automatic rand_xfer(input int d);
        int          w = (d == 0) ? 2 : 0;
        int          r = $urandom_range(0, 9);
        int          m;
        int          sk = 0;
        logic [31:0] a;
        if (r < 7)      a = $urandom_range(0, DEPTH - 1);
        else if (r < 9) a = $urandom_range(DEPTH, 40);
        else            a = $urandom() | 32'h0000_0100;
        r = $urandom_range(0, 19);
        if (r < 14) m = M_NONE;
        else if (r < 16) begin m = M_ABORT; sk = $urandom_range(1, w + 1); end
        else if (r < 19 && w > 0) begin m = M_RESTART; sk = $urandom_range(1, w); end
        else if (r == 19) begin m = M_RESET; sk = $urandom_range(1, w + 1); end
        else m = M_NONE;
        xfer(d, a, 1'($urandom_range(0, 1)), 8'($urandom()), m, sk);
        if (m != M_RESTART) repeat ($urandom_range(0, 2)) idle(d);
    endtask

    initial begin
        for (int d = 0; d < 2; d++) begin
            preset[d] = 1'b1; psel[d] = 1'b0; penable[d] = 1'b0; pwrite[d] = 1'b0;
            paddr[d] = '0; pwdata[d] = '0;
            exp_pready[d] = 1'b0; exp_pslverr[d] = 1'b0; exp_prdata[d] = 8'h00;
        end
        @(posedge PCLK);
        #1;
        for (int d = 0; d < 2; d++)
            for (int i = 0; i < DEPTH; i++) mem_m[d][i] = 8'h00;
        chk_en = 1'b1;
        @(posedge PCLK);
        #1;
        preset[0] = 1'b0;
        preset[1] = 1'b0;

        xfer(0, 32'h0, 1'b0, 8'h00, M_NONE, 0);
        lit("rst_rd0", 0, 1'b1, 8'h00, 1'b0);
        idle(0);

        xfer(0, 32'h3, 1'b1, 8'hA5, M_NONE, 0);
        lit("wr3", 0, 1'b1, 8'h00, 1'b0);
        xfer(0, 32'h3, 1'b0, 8'h00, M_NONE, 0);
        lit("rd3", 0, 1'b1, 8'hA5, 1'b0);

        xfer(0, 32'h10, 1'b1, 8'h5A, M_NONE, 0);
        lit("oor_wr", 0, 1'b1, 8'hA5, 1'b1);
        xfer(0, 32'h10, 1'b0, 8'h00, M_NONE, 0);
        lit("oor_rd", 0, 1'b1, 8'h00, 1'b1);
        xfer(0, 32'h0, 1'b0, 8'h00, M_NONE, 0);
        lit("oor_alias0", 0, 1'b1, 8'h00, 1'b0);
        xfer(0, 32'h8000_0003, 1'b1, 8'hEE, M_NONE, 0);
        lit("hi_wr", 0, 1'b0, 8'h00, 1'b1);
        xfer(0, 32'h3, 1'b0, 8'h00, M_NONE, 0);
        lit("hi_alias3", 0, 1'b1, 8'hA5, 1'b0);

        for (int i = 0; i < 4; i++) xfer(0, 32'(i), 1'b1, 8'((i + 1) * 17), M_NONE, 0);
        for (int i = 0; i < 4; i++) begin
            xfer(0, 32'(i), 1'b0, 8'h00, M_NONE, 0);
            lit($sformatf("b2b_rd%0d", i), 0, 1'b1, 8'((i + 1) * 17), 1'b0);
        end
        idle(0);

        xfer(0, 32'h2, 1'b1, 8'hFF, M_ABORT, 1);
        idle(0);
        xfer(0, 32'h2, 1'b0, 8'h00, M_NONE, 0);
        lit("abort_rd2", 0, 1'b1, 8'h33, 1'b0);

        xfer(0, 32'h5, 1'b1, 8'h77, M_RESTART, 1);
        xfer(0, 32'h6, 1'b1, 8'h66, M_NONE, 0);
        xfer(0, 32'h5, 1'b0, 8'h00, M_NONE, 0);
        lit("restart_rd5", 0, 1'b1, 8'h00, 1'b0);
        xfer(0, 32'h6, 1'b0, 8'h00, M_NONE, 0);
        lit("restart_rd6", 0, 1'b1, 8'h66, 1'b0);

        xfer(0, 32'h1, 1'b1, 8'h99, M_RESET, 3);
        xfer(0, 32'h1, 1'b0, 8'h00, M_NONE, 0);
        lit("rstresp_rd1", 0, 1'b1, 8'h00, 1'b0);
        xfer(0, 32'h2, 1'b0, 8'h00, M_NONE, 0);
        lit("rstresp_rd2", 0, 1'b1, 8'h00, 1'b0);
        idle(0);

        xfer(1, 32'hF, 1'b1, 8'hC3, M_NONE, 0);
        lit("zw_wr", 1, 1'b1, 8'h00, 1'b0);
        xfer(1, 32'hF, 1'b0, 8'h00, M_NONE, 0);
        lit("zw_rd", 1, 1'b1, 8'hC3, 1'b0);
        idle(1);

        for (int n = 0; n < 200; n++) rand_xfer(0);
        idle(0);
        for (int n = 0; n < 80; n++) rand_xfer(1);
        idle(1);
        idle(1);

        chk_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
